// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared processor definitions used by the functional units and the data
//   memory arbiter: bus command and access-size encodings, the FU-to-memory
//   packet, the arbiter state encoding and the grant IDs.
// -----------------------------------------------------------------------------
package sys_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        BUS_COMMAND        proc2Dmem_command;
        logic [XLEN-1:0]   proc2Dmem_addr;
        logic [XLEN-1:0]   proc2Dmem_data;
        MEM_SIZE           proc2Dmem_size;
    } FU_MEM_PACKET;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'h0,
        ARB_BUSY = 2'h1,
        ARB_DONE = 2'h2
    } DMEM_ARB_STATE;

    // Grant IDs: bit positions in the rr_arb2 request/grant vectors.
    localparam logic GRANT_LD = 1'b0;
    localparam logic GRANT_ST = 1'b1;

    // What the memory sees whenever no access is in flight.
    localparam FU_MEM_PACKET IDLE_PACKET = '{
        proc2Dmem_command: BUS_NONE,
        proc2Dmem_addr:    '0,
        proc2Dmem_data:    '0,
        proc2Dmem_size:    BYTE
    };

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin selector. A lone request wins outright; when both are
//   present, the one that was not granted last wins.
//
//   req[1:0]    in   request vector (bit 0 = load, bit 1 = store)
//   last_grant  in   ID of the requester granted most recently
//   grant[1:0]  out  one-hot grant, all zero when nothing is requested
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // NOTE: the output gets a default before the case so every path assigns
    // it; without that, an uncovered path would infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the load and store FUs.
//   IDLE picks a winner (round-robin) and latches its packet, BUSY presents
//   that packet until the memory answers, DONE pulses the winner's ack for
//   one cycle. Load data is passed through raw; extension is the load FU's
//   job. A BUSY-cycle watchdog raises a sticky timeout_err.
//
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   ld_req           in   load FU request, held until ld_ack
//   ld_packet        in   load command/addr/data/size
//   ld_ack           out  one-cycle load completion pulse
//   ld_data          out  raw load data, held until the next load capture
//   st_req           in   store FU request, held until st_ack
//   st_packet        in   store command/addr/data/size
//   st_ack           out  one-cycle store completion pulse
//   dmem_packet      out  command to data memory (BUS_NONE, zeros when idle)
//   Dmem2proc_data   in   memory read data
//   Dmem2proc_valid  in   memory response strobe, one cycle
//   timeout_err      out  sticky watchdog flag
// -----------------------------------------------------------------------------
module dmem_arbiter
    import sys_defs::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_req,
    input  FU_MEM_PACKET    ld_packet,
    output logic            ld_ack,
    output logic [XLEN-1:0] ld_data,
    input  logic            st_req,
    input  FU_MEM_PACKET    st_packet,
    output logic            st_ack,
    output FU_MEM_PACKET    dmem_packet,
    input  logic [XLEN-1:0] Dmem2proc_data,
    input  logic            Dmem2proc_valid,
    output logic            timeout_err
);

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX_M1 = CNT_W'(TIMEOUT - 1);

    DMEM_ARB_STATE    state;
    logic [1:0]       rr_grant;
    logic             grant_q;
    logic             last_grant_q;
    FU_MEM_PACKET     pkt_q;
    logic [CNT_W-1:0] busy_cnt;
    logic             err_q;
    logic [XLEN-1:0]  ld_data_q;

    rr_arb2 u_rr_arb2 (
        .req        ({st_req, ld_req}),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ARB_IDLE;
            grant_q      <= GRANT_LD;
            last_grant_q <= GRANT_ST;   // load wins the first tie
            pkt_q        <= IDLE_PACKET;
            busy_cnt     <= '0;
            err_q        <= 1'b0;
            ld_data_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (rr_grant != 2'b00) begin
                        grant_q      <= rr_grant[1];
                        last_grant_q <= rr_grant[1];
                        pkt_q        <= rr_grant[1] ? st_packet : ld_packet;
                        busy_cnt     <= '0;
                        state        <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    // Saturating count of BUSY edges; the error flag sets on
                    // the edge that brings the count to TIMEOUT. A timeout
                    // does not abort the access; only a response or reset
                    // leaves BUSY.
                    if (busy_cnt != CNT_MAX) begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                    if (busy_cnt == CNT_MAX_M1) begin
                        err_q <= 1'b1;
                    end
                    if (Dmem2proc_valid) begin
                        state <= ARB_DONE;
                        if (grant_q == GRANT_LD) begin
                            ld_data_q <= Dmem2proc_data;
                        end
                    end
                end

                ARB_DONE: begin
                    // The requester drops its req on the ack edge, so no
                    // arbitration is attempted here.
                    state <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Acks decode straight from DONE and the single grant ID, so they are
    // mutually exclusive by construction.
    assign ld_ack      = (state == ARB_DONE) && (grant_q == GRANT_LD);
    assign st_ack      = (state == ARB_DONE) && (grant_q == GRANT_ST);
    assign dmem_packet = (state == ARB_BUSY) ? pkt_q : IDLE_PACKET;
    assign ld_data     = ld_data_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A small memory responder raises
//   Dmem2proc_valid in the mem_lat-th cycle of each access; a second instance
//   with TIMEOUT=8 and no memory exercises the watchdog.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import sys_defs::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            ld_req, st_req;
    FU_MEM_PACKET    ld_packet, st_packet, dmem_packet;
    logic            ld_ack, st_ack, timeout_err;
    logic [XLEN-1:0] ld_data, mem_data;
    logic            mem_valid, auto_valid, manual_valid, auto_mem;
    int              mem_lat;
    int              busy_seen;
    BUS_COMMAND      seen_cmd;
    logic [XLEN-1:0] seen_addr;

    logic            to_ld_req;
    FU_MEM_PACKET    to_ld_packet, to_st_packet, to_dmem_packet;
    logic            to_ld_ack, to_st_ack, to_err;
    logic [XLEN-1:0] to_ld_data;

    int total = 0;
    int bad   = 0;
    logic is_ld;

    always #5 clock = ~clock;

    assign mem_valid = auto_mem ? auto_valid : manual_valid;

    dmem_arbiter u_dut (
        .clock           (clock),
        .reset           (reset),
        .ld_req          (ld_req),
        .ld_packet       (ld_packet),
        .ld_ack          (ld_ack),
        .ld_data         (ld_data),
        .st_req          (st_req),
        .st_packet       (st_packet),
        .st_ack          (st_ack),
        .dmem_packet     (dmem_packet),
        .Dmem2proc_data  (mem_data),
        .Dmem2proc_valid (mem_valid),
        .timeout_err     (timeout_err)
    );

    dmem_arbiter #(.TIMEOUT(8)) u_dut_to (
        .clock           (clock),
        .reset           (reset),
        .ld_req          (to_ld_req),
        .ld_packet       (to_ld_packet),
        .ld_ack          (to_ld_ack),
        .ld_data         (to_ld_data),
        .st_req          (1'b0),
        .st_packet       (to_st_packet),
        .st_ack          (to_st_ack),
        .dmem_packet     (to_dmem_packet),
        .Dmem2proc_data  (32'h0),
        .Dmem2proc_valid (1'b0),
        .timeout_err     (to_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for the next ack (bounded), flag any overlap, report which one.
    task automatic wait_ack(input string tag, output logic got_ld);
        bit done = 1'b0;
        got_ld = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (ld_ack || st_ack) begin
                check({tag, " overlap"}, 128'(ld_ack & st_ack), 128'(0));
                got_ld = ld_ack;
                done   = 1'b1;
            end
        end
        check({tag, " ack seen"}, 128'(done), 128'(1));
    endtask

    // Memory responder: counts cycles with a live command, answers in the
    // mem_lat-th one, and records the first command/address of each access.
    initial begin
        auto_valid = 1'b0;
        busy_seen  = 0;
        seen_cmd   = BUS_NONE;
        seen_addr  = '0;
        forever begin
            step();
            if (dmem_packet.proc2Dmem_command != BUS_NONE) begin
                busy_seen++;
                if (busy_seen == 1) begin
                    seen_cmd  = dmem_packet.proc2Dmem_command;
                    seen_addr = dmem_packet.proc2Dmem_addr;
                end
            end else begin
                busy_seen = 0;
            end
            auto_valid = (busy_seen != 0) && (busy_seen == mem_lat);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ld_req       = 1'b0;
        st_req       = 1'b0;
        ld_packet    = IDLE_PACKET;
        st_packet    = IDLE_PACKET;
        mem_data     = '0;
        manual_valid = 1'b0;
        auto_mem     = 1'b1;
        mem_lat      = 3;
        to_ld_req    = 1'b0;
        to_ld_packet = IDLE_PACKET;
        to_st_packet = IDLE_PACKET;
        step();
        step();

        // Reset state
        check("rst ld_ack", 128'(ld_ack), 128'(0));
        check("rst st_ack", 128'(st_ack), 128'(0));
        check("rst ld_data", 128'(ld_data), 128'(0));
        check("rst dmem_packet", 128'(dmem_packet), 128'(0));
        check("rst timeout_err", 128'(timeout_err), 128'(0));
        reset = 1'b0;
        step();

        // Lone load, latency 3: BUS_LOAD for three cycles, ack in the fifth
        // cycle that ld_req is high.
        ld_packet = '{BUS_LOAD, 32'h100, 32'h0, WORD};
        mem_data  = 32'hDEADBEEF;
        ld_req    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                check($sformatf("t1 cmd c%0d", k), 128'(dmem_packet.proc2Dmem_command), 128'(BUS_LOAD));
                check($sformatf("t1 addr c%0d", k), 128'(dmem_packet.proc2Dmem_addr), 128'h100);
                check($sformatf("t1 no ack c%0d", k), 128'(ld_ack), 128'(0));
            end else begin
                check("t1 ld_ack", 128'(ld_ack), 128'(1));
                check("t1 cmd done", 128'(dmem_packet.proc2Dmem_command), 128'(BUS_NONE));
                check("t1 ld_data", 128'(ld_data), 128'hDEADBEEF);
            end
        end
        ld_req   = 1'b0;
        mem_data = 32'hCAFEF00D;
        repeat (3) step();
        check("t1 ack gone", 128'(ld_ack), 128'(0));
        check("t1 ld_data held", 128'(ld_data), 128'hDEADBEEF);

        // Simultaneous requests straight after reset: load first, then store.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        mem_lat   = 2;
        ld_packet = '{BUS_LOAD, 32'h40, 32'h0, WORD};
        st_packet = '{BUS_STORE, 32'h80, 32'h55, WORD};
        ld_req    = 1'b1;
        st_req    = 1'b1;
        wait_ack("t2 first", is_ld);
        check("t2 first is load", 128'(is_ld), 128'(1));
        check("t2 first cmd", 128'(seen_cmd), 128'(BUS_LOAD));
        ld_req = 1'b0;
        wait_ack("t2 second", is_ld);
        check("t2 second is load", 128'(is_ld), 128'(0));
        check("t2 second cmd", 128'(seen_cmd), 128'(BUS_STORE));
        check("t2 second addr", 128'(seen_addr), 128'h80);
        st_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2 no extra ack", 128'(ld_ack | st_ack), 128'(0));
        end

        // Both held for four accesses: last grant was store, so L,S,L,S.
        ld_req = 1'b1;
        st_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("t3 acc%0d", i), is_ld);
            check($sformatf("t3 acc%0d is load", i), 128'(is_ld), 128'((i % 2) == 0));
        end
        ld_req = 1'b0;
        st_req = 1'b0;
        step();
        step();

        // Packet input changes mid-BUSY must not reach the memory.
        mem_lat   = 4;
        ld_packet = '{BUS_LOAD, 32'h100, 32'h0, WORD};
        ld_req    = 1'b1;
        step();
        check("t4 cmd", 128'(dmem_packet.proc2Dmem_command), 128'(BUS_LOAD));
        ld_packet.proc2Dmem_addr = 32'h200;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("t4 addr held %0d", k), 128'(dmem_packet.proc2Dmem_addr), 128'h100);
        end
        wait_ack("t4", is_ld);
        check("t4 is load", 128'(is_ld), 128'(1));
        ld_req = 1'b0;
        step();

        // Reset in BUSY, then a late response: no ack, idle, ld_data cleared.
        auto_mem  = 1'b0;
        ld_packet = '{BUS_LOAD, 32'h300, 32'h0, WORD};
        mem_data  = 32'h12345678;
        ld_req    = 1'b1;
        step();
        check("t5 busy cmd", 128'(dmem_packet.proc2Dmem_command), 128'(BUS_LOAD));
        reset  = 1'b1;
        ld_req = 1'b0;
        step();
        check("t5 idle after reset", 128'(dmem_packet), 128'(0));
        reset        = 1'b0;
        manual_valid = 1'b1;
        step();
        manual_valid = 1'b0;
        check("t5 no ack", 128'(ld_ack | st_ack), 128'(0));
        check("t5 packet none", 128'(dmem_packet), 128'(0));
        check("t5 ld_data", 128'(ld_data), 128'(0));
        step();
        check("t5 no ack later", 128'(ld_ack | st_ack), 128'(0));
        auto_mem = 1'b1;

        // Watchdog (TIMEOUT=8, no response): error set by the 8th clock edge
        // spent in BUSY, FSM stays BUSY, flag holds until reset.
        to_ld_packet = '{BUS_LOAD, 32'h500, 32'h0, WORD};
        to_ld_req    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("t6 err c%0d", k), 128'(to_err), 128'(k == 9));
        end
        check("t6 still busy", 128'(to_dmem_packet.proc2Dmem_command), 128'(BUS_LOAD));
        to_ld_req = 1'b0;
        repeat (10) step();
        check("t6 err sticky", 128'(to_err), 128'(1));
        check("t6 busy held", 128'(to_dmem_packet.proc2Dmem_command), 128'(BUS_LOAD));
        check("t6 no ack", 128'(to_ld_ack | to_st_ack), 128'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6 err cleared", 128'(to_err), 128'(0));
        check("t6 idle", 128'(to_dmem_packet), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
